// File: rtl/branch_unit.sv
// Conditional-branch evaluator: captures an instruction and NZP flags on start,
// decides taken/illegal, computes the PC-relative target and counts taken branches.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// EVAL   | captured copies are evaluated; result registered on exit
// RESULT | done pulse (and ldPC if taken); returns to IDLE unconditionally
module branch_unit #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        IR,
    input  logic               N,
    input  logic               Z,
    input  logic               P,
    input  logic [15:0]        pcIn,
    output logic               busy,
    output logic               done,
    output logic               taken,
    output logic               ldPC,
    output logic               illegal,
    output logic [15:0]        target,
    output logic [COUNT_W-1:0] takenCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] ir_q;
    logic        n_q;
    logic        z_q;
    logic        p_q;
    logic [15:0] pc_q;

    logic        cond;
    logic        opc_ok;
    logic        new_taken;
    logic [15:0] new_target;

    // Evaluation looks only at the captured copies, never at the live inputs.
    always_comb begin
        cond       = (ir_q[11] & n_q) | (ir_q[10] & z_q) | (ir_q[9] & p_q);
        opc_ok     = (ir_q[15:12] == 4'b0000);
        new_taken  = cond & opc_ok;
        new_target = pc_q + {{7{ir_q[8]}}, ir_q[8:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ir_q       <= '0;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            p_q        <= 1'b0;
            pc_q       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            taken      <= 1'b0;
            ldPC       <= 1'b0;
            illegal    <= 1'b0;
            target     <= '0;
            takenCount <= '0;
        end else begin
            done <= 1'b0;
            ldPC <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ir_q  <= IR;
                        n_q   <= N;
                        z_q   <= Z;
                        p_q   <= P;
                        pc_q  <= pcIn;
                        busy  <= 1'b1;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    taken   <= new_taken;
                    illegal <= ~opc_ok;
                    target  <= new_target;
                    done    <= 1'b1;
                    ldPC    <= new_taken;
                    if (new_taken) begin
                        takenCount <= takenCount + COUNT_W'(1);
                    end
                    state <= RESULT;
                end
                RESULT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 The block SHALL take one parameter, written as name, default, meaning: COUNT_W, 8, width of the taken-branch counter.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have this port: clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have this port: reset  input  1  synchronous, active-high; acts on the clk rising edge.
REQ-005 The block SHALL have this port: start  input  1  request to evaluate one instruction; sampled on a clk edge.
REQ-006 The block SHALL have this port: IR  input  16  instruction word; opcode IR[15:12], condition bits n/z/p in IR[11:9], PCoffset9 in IR[8:0].
REQ-007 The block SHALL have these ports: N, Z, P  input  1 each  condition flags from the NZP flag register.
REQ-008 The block SHALL have this port: pcIn  input  16  already-incremented PC.
REQ-009 The block SHALL have this port: busy  output  1  high in EVAL and RESULT.
REQ-010 The block SHALL have this port: done  output  1  one-cycle pulse in RESULT.
REQ-011 The block SHALL have this port: taken  output  1  registered branch decision.
REQ-012 The block SHALL have this port: ldPC  output  1  PC load enable; equals done AND taken.
REQ-013 The block SHALL have this port: illegal  output  1  registered flag; the captured opcode was not 0000.
REQ-014 The block SHALL have this port: target  output  16  registered branch target.
REQ-015 The block SHALL have this port: takenCount  output  COUNT_W  number of taken branches, wrapping.

Function
REQ-016 The FSM SHALL have three states: IDLE, EVAL and RESULT.
REQ-017 The FSM SHALL follow these transitions: IDLE to EVAL on start=1; EVAL to RESULT unconditionally; RESULT to IDLE unconditionally.
REQ-018 On the edge that leaves IDLE, the block SHALL capture IR, N, Z, P and pcIn into internal registers; all later evaluation SHALL use only the captured copies.
REQ-019 A start seen in EVAL or RESULT SHALL be ignored; it is not queued and has no effect.
REQ-020 Condition: cond = (IR[11]&N) | (IR[10]&Z) | (IR[9]&P), computed from captured values.
REQ-021 Condition boundaries: nzp=000 is never taken; nzp=111 is always taken.
REQ-022 If more than one flag is set, cond SHALL still be the OR above, with no error raised.
REQ-023 If the captured opcode is not 0000, the block SHALL set illegal=1 and taken=0; target is still computed.
REQ-024 Target: target = pcIn + sign-extended IR[8:0], modulo 2^16; wrap-around in either direction is silent.
REQ-025 taken, illegal and target SHALL be registered on the EVAL-to-RESULT edge.
REQ-026 taken, illegal and target SHALL hold their values until the next EVAL completes.
REQ-027 Latency: done SHALL be high for exactly one cycle, in the cycle after two edges following the start-sampling edge.
REQ-028 Back-to-back starts SHALL be accepted no faster than once every 3 cycles.
REQ-029 ldPC SHALL be high only in the cycle where done=1 and taken=1.
REQ-030 busy SHALL be 1 in EVAL and RESULT and 0 in IDLE.
REQ-031 takenCount SHALL increment by 1 on the EVAL-to-RESULT edge when the new taken=1.
REQ-032 takenCount SHALL wrap from 2^COUNT_W-1 to 0.

Reset
REQ-033 When reset=1 at a clk edge, the block SHALL go to IDLE and clear busy, done, taken, ldPC, illegal, target=0x0000, takenCount=0 and all captured registers.
REQ-034 Reset SHALL take priority over start, including when both are high at the same edge.
REQ-035 A reset asserted in EVAL or RESULT SHALL abort the operation: done and ldPC are not asserted for it, and takenCount is not incremented.

Verification
REQ-036 Scenario: IR=0x0E05, pcIn=0x3001, N=0 Z=1 P=0, start pulse -> done and ldPC high 2 cycles later, taken=1, target=0x3006, takenCount=1.
REQ-037 Scenario: IR=0x0801, pcIn=0x3001, P=1 only -> taken=0, ldPC=0, done=1, target=0x3002, takenCount unchanged.
REQ-038 Scenario: IR=0x03FF, pcIn=0x0000, P=1 -> taken=1, target=0xFFFF; IR=0x0E01, pcIn=0xFFFF -> target=0x0000.
REQ-039 Scenario: start, then toggle flags to N=1 and pulse start during EVAL -> result uses flags sampled at start, and exactly one done pulse.
REQ-040 Scenario: IR=0x1E05 with Z=1 -> illegal=1, taken=0, ldPC=0; then IR=0x0000 -> illegal=0, taken=0.
REQ-041 Scenario: reset during EVAL -> busy=0 the next cycle, no done, takenCount=0; 256 taken branches with COUNT_W=8 -> takenCount=0x00.
